// File: rtl/manchester_frame_axis.sv
// Frame assembler behind the Manchester decoder: CRC-8 checked frames go into a commit/rollback FIFO and leave as AXI-Stream packets.
// Optional macro MFA_DROP_BAD_CRC_EN: roll back bad-CRC frames instead of committing them with tuser=1.
module manchester_frame_axis #(
    parameter int FRAME_SIZE   = 4,
    parameter int DEPTH        = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  s_byte,
    input  logic        s_byte_valid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frame_cnt,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] timeout_cnt
);

    localparam int PAYLOAD_LEN = FRAME_SIZE - 1;
    localparam int AW          = $clog2(DEPTH);
    localparam int PW          = AW + 1;
    localparam int IW          = $clog2(FRAME_SIZE);
    localparam int TW          = $clog2(IDLE_TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CRC, ST_DISCARD} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } entry_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic [TW-1:0] idle_cnt, idle_next;
    logic [7:0]    crc, crc_next;
    logic [7:0]    held, held_next;
    logic [PW-1:0] wr_ptr, wr_ptr_next;
    logic [PW-1:0] cm_ptr, cm_ptr_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;
    logic          space_ok;
    logic          wr_en;
    entry_t        wr_entry;
    entry_t        rd_entry;
    logic          inc_frame, inc_err, inc_drop, inc_tout;
    entry_t        mem [DEPTH];

    assign used     = wr_ptr - rd_ptr;
    // Free space is judged against rd_ptr before any read in this same cycle.
    assign space_ok = (int'(used) <= DEPTH - PAYLOAD_LEN);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        idle_next   = '0;
        crc_next    = crc;
        held_next   = held;
        wr_ptr_next = wr_ptr;
        cm_ptr_next = cm_ptr;
        wr_en       = 1'b0;
        wr_entry    = '0;
        inc_frame   = 1'b0;
        inc_err     = 1'b0;
        inc_drop    = 1'b0;
        inc_tout    = 1'b0;

        if (state != ST_IDLE) begin
            idle_next = s_byte_valid ? '0 : idle_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                idx_next = '0;
                if (s_byte_valid) begin
                    idx_next = IW'(1);
                    if (space_ok) begin
                        crc_next = crc8_step(8'h00, s_byte);
                        if (FRAME_SIZE == 2) begin
                            held_next  = s_byte;
                            state_next = ST_CRC;
                        end else begin
                            wr_en       = 1'b1;
                            wr_entry    = '{data: s_byte, last: 1'b0, user: 1'b0};
                            wr_ptr_next = wr_ptr + 1'b1;
                            state_next  = ST_PAYLOAD;
                        end
                    end else begin
                        inc_drop   = 1'b1;
                        state_next = ST_DISCARD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (s_byte_valid) begin
                    crc_next = crc8_step(crc, s_byte);
                    idx_next = idx + 1'b1;
                    if (idx == IW'(FRAME_SIZE - 2)) begin
                        // The last payload byte waits here until the CRC verdict is known.
                        held_next  = s_byte;
                        state_next = ST_CRC;
                    end else begin
                        wr_en       = 1'b1;
                        wr_entry    = '{data: s_byte, last: 1'b0, user: 1'b0};
                        wr_ptr_next = wr_ptr + 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (s_byte_valid) begin
                    idx_next   = '0;
                    state_next = ST_IDLE;
`ifdef MFA_DROP_BAD_CRC_EN
                    if (s_byte != crc) begin
                        wr_ptr_next = cm_ptr;
                        inc_err     = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        wr_entry    = '{data: held, last: 1'b1, user: 1'b0};
                        wr_ptr_next = wr_ptr + 1'b1;
                        cm_ptr_next = wr_ptr + 1'b1;
                        inc_frame   = 1'b1;
                    end
`else
                    wr_en       = 1'b1;
                    wr_entry    = '{data: held, last: 1'b1, user: (s_byte != crc)};
                    wr_ptr_next = wr_ptr + 1'b1;
                    cm_ptr_next = wr_ptr + 1'b1;
                    inc_err     = (s_byte != crc);
                    inc_frame   = (s_byte == crc);
`endif
                end
            end
            ST_DISCARD: begin
                if (s_byte_valid) begin
                    if (idx == IW'(FRAME_SIZE - 1)) begin
                        idx_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A byte arriving in the expiry cycle keeps the frame alive.
        if (state != ST_IDLE && !s_byte_valid && idle_cnt == TW'(IDLE_TIMEOUT - 1)) begin
            wr_ptr_next = cm_ptr;
            idx_next    = '0;
            idle_next   = '0;
            inc_tout    = 1'b1;
            state_next  = ST_IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            idx         <= '0;
            idle_cnt    <= '0;
            crc         <= '0;
            held        <= '0;
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            rd_ptr      <= '0;
            frame_cnt   <= '0;
            crc_err_cnt <= '0;
            drop_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            idle_cnt <= idle_next;
            crc      <= crc_next;
            held     <= held_next;
            wr_ptr   <= wr_ptr_next;
            cm_ptr   <= cm_ptr_next;
            if (m_axis_tvalid && m_axis_tready) rd_ptr <= rd_ptr + 1'b1;
            if (inc_frame) frame_cnt   <= frame_cnt + 16'd1;
            if (inc_err)   crc_err_cnt <= crc_err_cnt + 16'd1;
            if (inc_drop)  drop_cnt    <= drop_cnt + 16'd1;
            if (inc_tout)  timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

    // NOTE: the buffer array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    assign rd_entry      = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = (cm_ptr != rd_ptr);
    assign m_axis_tdata  = m_axis_tvalid ? rd_entry.data : 8'h00;
    assign m_axis_tlast  = m_axis_tvalid ? rd_entry.last : 1'b0;
    assign m_axis_tuser  = m_axis_tvalid ? rd_entry.user : 1'b0;

endmodule

// File: tb/tb_manchester_frame_axis.sv
// Self-checking bench for manchester_frame_axis: frame-level reference model with per-cycle compare,
// directed literal scenarios, then randomized frames, gaps, corruption, stalls and resets.
module tb_manchester_frame_axis;

    localparam int FS    = 4;
    localparam int DEPTH = 16;
    localparam int TOUT  = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  s_byte;
    logic        s_byte_valid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] frame_cnt, crc_err_cnt, drop_cnt, timeout_cnt;

    logic [7:0]  b_byte;
    logic        b_valid;
    logic [7:0]  b_tdata;
    logic        b_tvalid;
    logic        b_tready;
    logic        b_tlast;
    logic        b_tuser;
    logic [15:0] b_frame_cnt, b_crc_err_cnt, b_drop_cnt, b_timeout_cnt;

    manchester_frame_axis #(.FRAME_SIZE(FS), .DEPTH(DEPTH), .IDLE_TIMEOUT(TOUT)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_byte(s_byte), .s_byte_valid(s_byte_valid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frame_cnt(frame_cnt), .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
    );

    manchester_frame_axis #(.FRAME_SIZE(2), .DEPTH(DEPTH), .IDLE_TIMEOUT(TOUT)) dut_fs2 (
        .aclk(aclk), .aresetn(aresetn), .s_byte(b_byte), .s_byte_valid(b_valid),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
        .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
        .frame_cnt(b_frame_cnt), .crc_err_cnt(b_crc_err_cnt), .drop_cnt(b_drop_cnt), .timeout_cnt(b_timeout_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    function automatic logic [7:0] crc3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return crc8_step(crc8_step(crc8_step(8'h00, a), b), c);
    endfunction

    // Reference model: frame position, collected bytes, committed-beat queue, counters.
    beat_t       outq [$];
    logic [7:0]  cur [$];
    int          pos;
    bit          dropping;
    int          gap;
    bit          do_pop;
    logic [15:0] m_frame, m_err, m_drop, m_tout;
    bit          run_cmp;

    task automatic model_finish();
        logic [7:0] c;
        bit         bad;
        beat_t      bt;
        c = 8'h00;
        for (int i = 0; i < FS - 1; i++) c = crc8_step(c, cur[i]);
        bad = (cur[FS-1] != c);
`ifdef MFA_DROP_BAD_CRC_EN
        if (!bad) begin
            for (int i = 0; i < FS - 1; i++) begin
                bt.data = cur[i]; bt.last = (i == FS - 2); bt.user = 1'b0;
                outq.push_back(bt);
            end
        end
`else
        for (int i = 0; i < FS - 1; i++) begin
            bt.data = cur[i]; bt.last = (i == FS - 2); bt.user = bad && (i == FS - 2);
            outq.push_back(bt);
        end
`endif
        if (bad) m_err = m_err + 16'd1;
        else     m_frame = m_frame + 16'd1;
    endtask

    always @(posedge aclk) begin
        if (!aresetn) begin
            outq.delete(); cur.delete();
            pos = 0; dropping = 0; gap = 0;
            m_frame = '0; m_err = '0; m_drop = '0; m_tout = '0;
        end else begin
            do_pop = (outq.size() != 0) && m_axis_tready;
            if (s_byte_valid) begin
                gap = 0;
                if (pos == 0) begin
                    cur.delete();
                    if (DEPTH - outq.size() >= FS - 1) begin
                        dropping = 0;
                        cur.push_back(s_byte);
                    end else begin
                        dropping = 1;
                        m_drop = m_drop + 16'd1;
                    end
                    pos = 1;
                end else begin
                    pos++;
                    if (!dropping) cur.push_back(s_byte);
                end
                if (pos == FS) begin
                    if (!dropping) model_finish();
                    pos = 0; dropping = 0; cur.delete();
                end
            end else if (pos > 0) begin
                if (gap == TOUT - 1) begin
                    m_tout = m_tout + 16'd1;
                    pos = 0; gap = 0; dropping = 0; cur.delete();
                end else begin
                    gap++;
                end
            end
            if (do_pop) void'(outq.pop_front());
        end
    end

    beat_t seen [$];

    function automatic beat_t seen_at(input int i);
        if (i < seen.size()) return seen[i];
        return '1;
    endfunction

    always @(negedge aclk) begin
        if (run_cmp && aresetn) begin
            if (outq.size() != 0) begin
                check("tvalid", 32'(m_axis_tvalid), 1);
                check("tdata", 32'(m_axis_tdata), 32'(outq[0].data));
                check("tlast", 32'(m_axis_tlast), 32'(outq[0].last));
                check("tuser", 32'(m_axis_tuser), 32'(outq[0].user));
            end else begin
                check("tvalid_empty", 32'(m_axis_tvalid), 0);
                check("outputs_empty", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 0);
            end
            check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
            check("crc_err_cnt", 32'(crc_err_cnt), 32'(m_err));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("timeout_cnt", 32'(timeout_cnt), 32'(m_tout));
            if (m_axis_tvalid && m_axis_tready)
                seen.push_back(beat_t'({m_axis_tdata, m_axis_tlast, m_axis_tuser}));
        end
    end

    // 0: tready high, 1: tready low, 2: random tready.
    int rdy_mode = 0;
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'b0;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic cyc(input logic v, input logic [7:0] b);
        @(posedge aclk); #1;
        s_byte_valid = v;
        s_byte       = b;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    task automatic frame4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] k);
        cyc(1'b1, a); cyc(1'b1, b); cyc(1'b1, c); cyc(1'b1, k);
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        aresetn = 1'b0; s_byte_valid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
    endtask

    logic [7:0] pb [3];
    logic [7:0] kb;
    int         r, long_at, rst_at;

    initial begin
        aresetn = 1'b0; s_byte = 8'h00; s_byte_valid = 1'b0;
        b_byte = 8'h00; b_valid = 1'b0; b_tready = 1'b1;
        run_cmp = 0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        run_cmp = 1;
        check("reset_tvalid", 32'(m_axis_tvalid), 0);
        check("reset_counters", 32'({frame_cnt, crc_err_cnt} | {drop_cnt, timeout_cnt}), 0);

        // Good frame, sink always ready.
        seen.delete();
        frame4(8'h01, 8'h02, 8'h03, 8'h48); idle(6);
        check("t1_beats", seen.size(), 3);
        check("t1_b0", 32'(seen_at(0)), 32'({8'h01, 2'b00}));
        check("t1_b1", 32'(seen_at(1)), 32'({8'h02, 2'b00}));
        check("t1_b2", 32'(seen_at(2)), 32'({8'h03, 2'b10}));
        check("t1_frame_cnt", 32'(frame_cnt), 1);

        // Bad CRC.
        do_reset(); seen.delete();
        frame4(8'h01, 8'h02, 8'h03, 8'h49); idle(6);
`ifdef MFA_DROP_BAD_CRC_EN
        check("t2_beats", seen.size(), 0);
`else
        check("t2_beats", seen.size(), 3);
        check("t2_b2", 32'(seen_at(2)), 32'({8'h03, 2'b11}));
`endif
        check("t2_crc_err_cnt", 32'(crc_err_cnt), 1);
        check("t2_frame_cnt", 32'(frame_cnt), 0);

        // Stalled sink: sixth frame finds no room.
        do_reset(); seen.delete(); rdy_mode = 1;
        repeat (6) frame4(8'h01, 8'h02, 8'h03, 8'h48);
        idle(2);
        @(negedge aclk);
        check("t3_drop_cnt", 32'(drop_cnt), 1);
        check("t3_frame_cnt", 32'(frame_cnt), 5);
        check("t3_tvalid_held", 32'(m_axis_tvalid), 1);
        check("t3_tdata_held", 32'(m_axis_tdata), 32'h01);
        rdy_mode = 0; idle(25);
        check("t3_beats", seen.size(), 15);
        check("t3_b14", 32'(seen_at(14)), 32'({8'h03, 2'b10}));

        // Idle timeout mid-frame, then a clean frame.
        do_reset(); seen.delete();
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); idle(65);
        @(negedge aclk);
        check("t4_timeout_cnt", 32'(timeout_cnt), 1);
        check("t4_tvalid", 32'(m_axis_tvalid), 0);
        frame4(8'hAA, 8'hBB, 8'hCC, crc3(8'hAA, 8'hBB, 8'hCC)); idle(6);
        check("t4_beats", seen.size(), 3);
        check("t4_b0", 32'(seen_at(0)), 32'({8'hAA, 2'b00}));
        check("t4_b1", 32'(seen_at(1)), 32'({8'hBB, 2'b00}));
        check("t4_b2", 32'(seen_at(2)), 32'({8'hCC, 2'b10}));

        // Two-byte frames on the second instance.
        @(posedge aclk); #1 b_byte = 8'h01; b_valid = 1'b1;
        @(posedge aclk); #1 b_byte = 8'h07;
        @(posedge aclk); #1 b_valid = 1'b0;
        @(negedge aclk);
        check("t5_tvalid", 32'(b_tvalid), 1);
        check("t5_beat", 32'({b_tdata, b_tlast, b_tuser}), 32'({8'h01, 2'b10}));
        check("t5_frame_cnt", 32'(b_frame_cnt), 1);
        @(posedge aclk); #1;
        check("t5_drained", 32'(b_tvalid), 0);

        // Reset during a frame with data buffered.
        do_reset(); seen.delete(); rdy_mode = 1;
        frame4(8'h01, 8'h02, 8'h03, 8'h48);
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); cyc(1'b0, 8'h00);
        do_reset();
        check("t6_tvalid", 32'(m_axis_tvalid), 0);
        check("t6_counters", 32'({frame_cnt, crc_err_cnt} | {drop_cnt, timeout_cnt}), 0);
        rdy_mode = 0; seen.delete();
        frame4(8'h10, 8'h20, 8'h30, crc3(8'h10, 8'h20, 8'h30)); idle(6);
        check("t6_beats", seen.size(), 3);
        check("t6_b2", 32'(seen_at(2)), 32'({8'h30, 2'b10}));
        check("t6_frame_cnt", 32'(frame_cnt), 1);

        // Randomized traffic checked cycle by cycle against the model.
        for (int f = 0; f < 400; f++) begin
            r = $urandom_range(0, 9);
            rdy_mode = (r < 6) ? 2 : ((r < 8) ? 0 : 1);
            for (int i = 0; i < 3; i++) pb[i] = 8'($urandom);
            kb = crc3(pb[0], pb[1], pb[2]);
            if ($urandom_range(0, 5) == 0) kb = kb ^ (8'h01 << $urandom_range(0, 7));
            long_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            rst_at  = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 3)) : -1;
            for (int i = 0; i < 4; i++) begin
                cyc(1'b1, (i < 3) ? pb[i] : kb);
                if (i == rst_at)       do_reset();
                else if (i == long_at) idle(int'($urandom_range(62, 66)));
                else                   idle(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4)));
            end
            if ($urandom_range(0, 29) == 0) cyc(1'b1, 8'($urandom));
        end

        rdy_mode = 0;
        idle(80);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
